// File: rtl/rv_decode_stage.sv
// RV32I/RV64I decode pipeline stage: combinational decode, registered output,
// one-entry skid buffer, flush, and a saturating handshake counter.
module rv_decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter bit          RV64  = 1'b0,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [2:0]       out_instr_type,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic             out_funct7_5,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_save_to_reg,
    output logic             out_rs1_used,
    output logic             out_rs2_used,
    output logic             out_immediate_used,
    output logic             out_is_branch,
    output logic             out_rd_memory,
    output logic             out_wr_memory,
    output logic             out_is_alu_sum,
    output logic             out_illegal,
    output logic [CNT_W-1:0] decoded_count
);

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [2:0] T_R = 3'd0;
    localparam logic [2:0] T_I = 3'd1;
    localparam logic [2:0] T_S = 3'd2;
    localparam logic [2:0] T_B = 3'd3;
    localparam logic [2:0] T_U = 3'd4;
    localparam logic [2:0] T_J = 3'd5;
    localparam logic [2:0] T_N = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [2:0]      itype;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic            funct7_5;
        logic [XLEN-1:0] imm;
        logic            save_to_reg;
        logic            rs1_used;
        logic            rs2_used;
        logic            immediate_used;
        logic            is_branch;
        logic            rd_memory;
        logic            wr_memory;
        logic            is_alu_sum;
        logic            illegal;
    } dec_t;

    dec_t             dec_c;
    dec_t             out_q, out_d, skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept_c, out_hs_c;

    logic [6:0]       opcode;
    logic [2:0]       f3;
    logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign imm_i  = XLEN'($signed(in_instr[31:20]));
    assign imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

    assign accept_c = in_valid && in_ready_q;
    assign out_hs_c = out_valid_q && out_ready;

    // Classify the incoming instruction; illegal encodings collapse to type N.
    always_comb begin
        dec_c          = '0;
        dec_c.pc       = in_pc;
        dec_c.rd       = in_instr[11:7];
        dec_c.rs1      = in_instr[19:15];
        dec_c.rs2      = in_instr[24:20];
        dec_c.funct3   = f3;
        dec_c.funct7_5 = in_instr[30];
        dec_c.itype    = T_N;
        case (opcode)
            OPC_LOAD: begin
                dec_c.itype = T_I; dec_c.imm = imm_i;
                dec_c.save_to_reg = 1'b1; dec_c.rs1_used = 1'b1;
                dec_c.immediate_used = 1'b1; dec_c.rd_memory = 1'b1;
                dec_c.illegal = RV64 ? (f3 == 3'b111) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                dec_c.itype = T_I; dec_c.imm = imm_i;
                dec_c.save_to_reg = 1'b1; dec_c.rs1_used = 1'b1; dec_c.immediate_used = 1'b1;
                dec_c.illegal = (opcode == OPC_OP_IMM_32) && !RV64;
            end
            OPC_AUIPC, OPC_LUI: begin
                dec_c.itype = T_U; dec_c.imm = imm_u;
                dec_c.save_to_reg = 1'b1; dec_c.immediate_used = 1'b1; dec_c.is_alu_sum = 1'b1;
            end
            OPC_STORE: begin
                dec_c.itype = T_S; dec_c.imm = imm_s;
                dec_c.rs1_used = 1'b1; dec_c.rs2_used = 1'b1;
                dec_c.immediate_used = 1'b1; dec_c.wr_memory = 1'b1;
                dec_c.illegal = RV64 ? (f3 > 3'b011) : (f3 > 3'b010);
            end
            OPC_OP, OPC_OP_32: begin
                dec_c.itype = T_R;
                dec_c.save_to_reg = 1'b1; dec_c.rs1_used = 1'b1; dec_c.rs2_used = 1'b1;
                dec_c.illegal = (opcode == OPC_OP_32) && !RV64;
            end
            OPC_BRANCH: begin
                dec_c.itype = T_B; dec_c.imm = imm_b;
                dec_c.rs1_used = 1'b1; dec_c.rs2_used = 1'b1;
                dec_c.immediate_used = 1'b1; dec_c.is_branch = 1'b1;
                dec_c.illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_JALR: begin
                dec_c.itype = T_I; dec_c.imm = imm_i;
                dec_c.save_to_reg = 1'b1; dec_c.rs1_used = 1'b1; dec_c.immediate_used = 1'b1;
                dec_c.is_branch = 1'b1; dec_c.is_alu_sum = 1'b1;
                dec_c.illegal = (f3 != 3'b000);
            end
            OPC_JAL: begin
                dec_c.itype = T_J; dec_c.imm = imm_j;
                dec_c.save_to_reg = 1'b1; dec_c.immediate_used = 1'b1;
                dec_c.is_branch = 1'b1; dec_c.is_alu_sum = 1'b1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: dec_c.itype = T_I;
            default: dec_c.illegal = 1'b1;
        endcase
        if (dec_c.illegal) begin
            dec_c.itype          = T_N;
            dec_c.imm            = '0;
            dec_c.save_to_reg    = 1'b0;
            dec_c.rs1_used       = 1'b0;
            dec_c.rs2_used       = 1'b0;
            dec_c.immediate_used = 1'b0;
            dec_c.is_branch      = 1'b0;
            dec_c.rd_memory      = 1'b0;
            dec_c.wr_memory      = 1'b0;
            dec_c.is_alu_sum     = 1'b0;
        end
    end

    // Output/skid buffer steering; flush drops everything including the concurrent input.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;
        if (out_hs_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_hs_c) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept_c) begin
                out_d       = dec_c;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            skid_d       = dec_c;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready           = in_ready_q;
    assign out_valid          = out_valid_q;
    assign out_pc             = out_q.pc;
    assign out_instr_type     = out_q.itype;
    assign out_rd             = out_q.rd;
    assign out_rs1            = out_q.rs1;
    assign out_rs2            = out_q.rs2;
    assign out_funct3         = out_q.funct3;
    assign out_funct7_5       = out_q.funct7_5;
    assign out_imm            = out_q.imm;
    assign out_save_to_reg    = out_q.save_to_reg;
    assign out_rs1_used       = out_q.rs1_used;
    assign out_rs2_used       = out_q.rs2_used;
    assign out_immediate_used = out_q.immediate_used;
    assign out_is_branch      = out_q.is_branch;
    assign out_rd_memory      = out_q.rd_memory;
    assign out_wr_memory      = out_q.wr_memory;
    assign out_is_alu_sum     = out_q.is_alu_sum;
    assign out_illegal        = out_q.illegal;
    assign decoded_count      = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage (XLEN=32, RV64=0, CNT_W=2).
module tb_rv_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [2:0]  out_instr_type, out_funct3;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic        out_funct7_5, out_illegal;
    logic        out_save_to_reg, out_rs1_used, out_rs2_used, out_immediate_used;
    logic        out_is_branch, out_rd_memory, out_wr_memory, out_is_alu_sum;
    logic [1:0]  decoded_count;
    logic [7:0]  flags;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign flags = {out_save_to_reg, out_rs1_used, out_rs2_used, out_immediate_used,
                    out_is_branch, out_rd_memory, out_wr_memory, out_is_alu_sum};

    rv_decode_stage #(.XLEN(32), .RV64(1'b0), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr_type(out_instr_type), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7_5(out_funct7_5), .out_imm(out_imm),
        .out_save_to_reg(out_save_to_reg), .out_rs1_used(out_rs1_used),
        .out_rs2_used(out_rs2_used), .out_immediate_used(out_immediate_used),
        .out_is_branch(out_is_branch), .out_rd_memory(out_rd_memory),
        .out_wr_memory(out_wr_memory), .out_is_alu_sum(out_is_alu_sum),
        .out_illegal(out_illegal), .decoded_count(decoded_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'h0; in_pc = 32'h0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Present one instruction for a single cycle.
    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'h0; in_pc = 32'h0;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", in_ready); else n_pass++;
        n_checks++; if (decoded_count !== 2'd0) $display("FAIL reset_count: got %0d want 0", decoded_count); else n_pass++;
        n_checks++; if ({out_pc, out_imm, out_instr_type, out_illegal, flags} !== '0)
            $display("FAIL reset_data: got pc=%h imm=%h type=%0d ill=%0b flags=%b want all 0",
                     out_pc, out_imm, out_instr_type, out_illegal, flags); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %0b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_stream();
        do_reset();
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_instr_type !== 3'd1 || out_imm !== 32'd5 || out_rd !== 5'd1 || flags !== 8'b1101_0000)
            $display("FAIL stream_addi: got v=%0b type=%0d imm=%h rd=%0d flags=%b want v=1 type=1 imm=5 rd=1 flags=11010000",
                     out_valid, out_instr_type, out_imm, out_rd, flags); else n_pass++;
        in_instr = 32'h0080A103; in_pc = 32'h104;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_pc !== 32'h104 || out_imm !== 32'd8 || out_rs1 !== 5'd1 || out_rd !== 5'd2 || out_funct3 !== 3'b010 || flags !== 8'b1101_0100)
            $display("FAIL stream_lw: got pc=%h imm=%h rs1=%0d rd=%0d f3=%0d flags=%b want pc=104 imm=8 rs1=1 rd=2 f3=2 flags=11010100",
                     out_pc, out_imm, out_rs1, out_rd, out_funct3, flags); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0 || decoded_count !== 2'd2)
            $display("FAIL stream_count: got v=%0b cnt=%0d want v=0 cnt=2", out_valid, decoded_count); else n_pass++;
    endtask

    task automatic test_immediates();
        do_reset();
        push(32'h0020A623, 32'h10);
        n_checks++; if (out_instr_type !== 3'd2 || out_imm !== 32'd12 || out_rs2 !== 5'd2 || flags !== 8'b0111_0010)
            $display("FAIL imm_sw: got type=%0d imm=%h rs2=%0d flags=%b want type=2 imm=c rs2=2 flags=01110010",
                     out_instr_type, out_imm, out_rs2, flags); else n_pass++;
        push(32'hFE208EE3, 32'h14);
        n_checks++; if (out_instr_type !== 3'd3 || out_imm !== 32'hFFFFFFFC || flags !== 8'b0111_1000)
            $display("FAIL imm_beq: got type=%0d imm=%h flags=%b want type=3 imm=fffffffc flags=01111000",
                     out_instr_type, out_imm, flags); else n_pass++;
        push(32'h001000EF, 32'h18);
        n_checks++; if (out_instr_type !== 3'd5 || out_imm !== 32'h800 || out_rd !== 5'd1 || flags !== 8'b1001_1001)
            $display("FAIL imm_jal: got type=%0d imm=%h rd=%0d flags=%b want type=5 imm=800 rd=1 flags=10011001",
                     out_instr_type, out_imm, out_rd, flags); else n_pass++;
        push(32'h123452B7, 32'h1C);
        n_checks++; if (out_instr_type !== 3'd4 || out_imm !== 32'h12345000 || out_rd !== 5'd5 || flags !== 8'b1001_0001)
            $display("FAIL imm_lui: got type=%0d imm=%h rd=%0d flags=%b want type=4 imm=12345000 rd=5 flags=10010001",
                     out_instr_type, out_imm, out_rd, flags); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h200;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || in_ready !== 1'b1)
            $display("FAIL bp_first: got v=%0b pc=%h rdy=%0b want v=1 pc=200 rdy=1", out_valid, out_pc, in_ready); else n_pass++;
        in_instr = 32'h00200093; in_pc = 32'h204;
        tick();
        n_checks++; if (in_ready !== 1'b0 || out_pc !== 32'h200 || out_imm !== 32'd1)
            $display("FAIL bp_skid_full: got rdy=%0b pc=%h imm=%h want rdy=0 pc=200 imm=1", in_ready, out_pc, out_imm); else n_pass++;
        in_instr = 32'h00300093; in_pc = 32'h208;
        tick();
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h200 || out_imm !== 32'd1 || decoded_count !== 2'd0)
            $display("FAIL bp_stall: got rdy=%0b v=%0b pc=%h imm=%h cnt=%0d want rdy=0 v=1 pc=200 imm=1 cnt=0",
                     in_ready, out_valid, out_pc, out_imm, decoded_count); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_pc !== 32'h204 || out_imm !== 32'd2 || in_ready !== 1'b1)
            $display("FAIL bp_drain_second: got pc=%h imm=%h rdy=%0b want pc=204 imm=2 rdy=1", out_pc, out_imm, in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h208 || out_imm !== 32'd3)
            $display("FAIL bp_drain_third: got v=%0b pc=%h imm=%h want v=1 pc=208 imm=3", out_valid, out_pc, out_imm); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0 || decoded_count !== 2'd3)
            $display("FAIL bp_done: got v=%0b cnt=%0d want v=0 cnt=3", out_valid, decoded_count); else n_pass++;
    endtask

    task automatic test_illegal();
        do_reset();
        push(32'h00000000, 32'h40);
        n_checks++; if (out_valid !== 1'b1 || out_instr_type !== 3'd7 || out_illegal !== 1'b1 || out_imm !== 32'h0 || flags !== 8'h00)
            $display("FAIL illegal_zero: got v=%0b type=%0d ill=%0b imm=%h flags=%b want v=1 type=7 ill=1 imm=0 flags=0",
                     out_valid, out_instr_type, out_illegal, out_imm, flags); else n_pass++;
        push(32'h0020A063, 32'h44);
        n_checks++; if (out_pc !== 32'h44 || out_instr_type !== 3'd7 || out_illegal !== 1'b1 || out_imm !== 32'h0 || flags !== 8'h00)
            $display("FAIL illegal_branch: got pc=%h type=%0d ill=%0b imm=%h flags=%b want pc=44 type=7 ill=1 imm=0 flags=0",
                     out_pc, out_instr_type, out_illegal, out_imm, flags); else n_pass++;
        tick();
        n_checks++; if (decoded_count !== 2'd2)
            $display("FAIL illegal_count: got %0d want 2", decoded_count); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        push(32'h00100093, 32'h300);
        push(32'h00200093, 32'h304);
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL flush_prefill: got rdy=%0b v=%0b want rdy=0 v=1", in_ready, out_valid); else n_pass++;
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00700093; in_pc = 32'h308;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || decoded_count !== 2'd0)
            $display("FAIL flush_clear: got v=%0b rdy=%0b cnt=%0d want v=0 rdy=1 cnt=0", out_valid, in_ready, decoded_count); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0)
            $display("FAIL flush_no_ghost: got v=%0b pc=%h want v=0", out_valid, out_pc); else n_pass++;
        // Input accepted in a flush cycle is discarded.
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00800093; in_pc = 32'h30C;
        tick();
        flush = 1'b0;
        n_checks++; if (out_valid !== 1'b0)
            $display("FAIL flush_drop_input: got v=%0b pc=%h want v=0", out_valid, out_pc); else n_pass++;
        in_instr = 32'h00900093; in_pc = 32'h310;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h310 || out_imm !== 32'd9)
            $display("FAIL flush_resume: got v=%0b pc=%h imm=%h want v=1 pc=310 imm=9", out_valid, out_pc, out_imm); else n_pass++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || decoded_count !== 2'd1)
            $display("FAIL flush_hs_counts: got v=%0b cnt=%0d want v=0 cnt=1", out_valid, decoded_count); else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h400;
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        tick();
        n_checks++; if (decoded_count !== 2'd3)
            $display("FAIL sat_count: got %0d want 3", decoded_count); else n_pass++;
        in_valid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || decoded_count !== 2'd0 || out_pc !== 32'h0 || out_imm !== 32'h0)
            $display("FAIL sat_midstream_reset: got v=%0b rdy=%0b cnt=%0d pc=%h imm=%h want all 0",
                     out_valid, in_ready, decoded_count, out_pc, out_imm); else n_pass++;
        rst = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_immediates();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
